// File: rtl/fp16_acc_pkg.sv
// Shared FP16 field layout, fixed-point output format and controller state
// encoding for the FP16 -> Q.8 conversion blocks.
package fp16_acc_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MAN_W    = 10;
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;
  localparam int unsigned FRAC_OUT = 8;

  // Exponent at which the implicit-one significand needs no shift to land
  // with FRAC_OUT fraction bits: EXP_BIAS + MAN_W - FRAC_OUT.
  localparam int unsigned FIX_POINT = EXP_BIAS + MAN_W - FRAC_OUT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/fp16_fix8_cvt.sv
// Combinational FP16 -> signed fixed point (8 fraction bits) converter.
// Zero/denormal inputs give 0; NaN/Inf give all-ones and flag exc.
module fp16_fix8_cvt
  import fp16_acc_pkg::*;
(
  input  logic [15:0] fp,
  output logic [15:0] fix,
  output logic        exc
);

  logic             sign;
  logic [EXP_W-1:0] exp_f;
  logic [15:0]      sig;
  logic [15:0]      mag;

  always_comb begin
    sign  = fp[15];
    exp_f = fp[14:10];
    sig   = 16'({1'b1, fp[MAN_W-1:0]});
    mag   = '0;
    fix   = '0;
    exc   = 1'b0;
    if (exp_f == '0) begin
      fix = '0;
    end else if (exp_f == EXP_W'(EXP_MAX)) begin
      fix = '1;
      exc = 1'b1;
    end else begin
      // Shifting inside 16 bits performs the required truncation.
      if (exp_f >= EXP_W'(FIX_POINT))
        mag = sig << (exp_f - EXP_W'(FIX_POINT));
      else
        mag = sig >> (EXP_W'(FIX_POINT) - exp_f);
      fix = sign ? (~mag + 16'd1) : mag;
    end
  end

endmodule

// File: rtl/fp16_fix_conv_ctrl.sv
// Job controller: streams len FP16 words from the source port, converts each
// to Q.8 and writes it to the destination port through a 2-entry result FIFO.
module fp16_fix_conv_ctrl
  import fp16_acc_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_abort,
  input  logic [AW-1:0] cfg_src_base,
  input  logic [AW-1:0] cfg_dst_base,
  input  logic [AW-1:0] cfg_len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] exc_cnt,
  output logic          src_req,
  output logic [AW-1:0] src_addr,
  input  logic [15:0]   src_rdata,
  output logic          dst_we,
  output logic [AW-1:0] dst_addr,
  output logic [15:0]   dst_wdata,
  input  logic          dst_ready
);

  state_t        state, state_nxt;
  logic [AW-1:0] src_base, dst_base, len_q, rd_idx, wr_cnt;
  logic          inflight;
  logic          accept_start, abort_job, push, pop, last_read, last_write;
  logic [15:0]   fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;
  logic [2:0]    occ;
  logic [15:0]   cvt_fix;
  logic          cvt_exc;

  fp16_fix8_cvt u_cvt (
    .fp  (src_rdata),
    .fix (cvt_fix),
    .exc (cvt_exc)
  );

  assign abort_job    = cfg_abort && (state != S_IDLE);
  assign accept_start = cfg_start && !cfg_abort && (state == S_IDLE);
  assign push         = inflight && !abort_job;
  assign dst_we       = (fifo_cnt != 2'd0);
  assign pop          = dst_we && dst_ready;
  // Slot being vacated this cycle counts as free, giving 1 element/cycle.
  assign occ          = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
  assign src_req      = (state == S_RUN) && (rd_idx != len_q) && (occ < 3'd2);
  assign src_addr     = src_base + rd_idx;
  assign dst_addr     = dst_base + wr_cnt;
  assign dst_wdata    = fifo_mem[rd_ptr];
  assign last_read    = src_req && (rd_idx == len_q - AW'(1));
  assign last_write   = pop && (wr_cnt == len_q - AW'(1));
  assign busy         = (state == S_RUN) || (state == S_DRAIN);
  assign done         = (state == S_DONE) && !cfg_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_start) state_nxt = (cfg_len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (last_read) state_nxt = S_DRAIN;
      S_DRAIN: if (last_write) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_job) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_base    <= '0;
      dst_base    <= '0;
      len_q       <= '0;
      rd_idx      <= '0;
      wr_cnt      <= '0;
      exc_cnt     <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (accept_start) begin
        src_base <= cfg_src_base;
        dst_base <= cfg_dst_base;
        len_q    <= cfg_len;
        rd_idx   <= '0;
        wr_cnt   <= '0;
        exc_cnt  <= '0;
      end else begin
        if (src_req) rd_idx <= rd_idx + AW'(1);
        if (pop)     wr_cnt <= wr_cnt + AW'(1);
      end
      inflight <= src_req && !abort_job;
      if (abort_job) begin
        fifo_cnt <= '0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= cvt_fix;
          wr_ptr           <= ~wr_ptr;
          if (cvt_exc && (exc_cnt != '1)) exc_cnt <= exc_cnt + AW'(1);
        end
        if (pop) rd_ptr <= ~rd_ptr;
        fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fp16_fix_conv_ctrl.sv
// Bench for fp16_fix_conv_ctrl: source memory responder, per-job expected
// result list built from the FP16 value rules, and a per-cycle checker.
module tb_fp16_fix_conv_ctrl;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [AW-1:0] cfg_src_base = '0;
  logic [AW-1:0] cfg_dst_base = '0;
  logic [AW-1:0] cfg_len = '0;
  logic          busy, done, src_req, dst_we;
  logic [AW-1:0] exc_cnt, src_addr, dst_addr;
  logic [15:0]   src_rdata = '0;
  logic [15:0]   dst_wdata;
  logic          dst_ready = 1'b1;

  fp16_fix_conv_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_len(cfg_len),
    .busy(busy), .done(done), .exc_cnt(exc_cnt),
    .src_req(src_req), .src_addr(src_addr), .src_rdata(src_rdata),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata), .dst_ready(dst_ready)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] src_mem [4096];

  bit          m_active = 0;
  int          m_src_base, m_dst_base, m_len, m_rd, m_wr, m_exc;
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  int          wr_addr_log[$], wr_cyc_log[$], rd_addr_log[$], rd_cyc_log[$];
  int          done_rel = -1, done_exc = -1;
  bit          done_seen = 0, busy_seen = 0;
  int          stall_from = 0, stall_n = 0;

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Value-level reference: value * 256 = (1.m) * 2^(e-15) * 256.
  function automatic logic [15:0] ref_cvt(input logic [15:0] w);
    int     e;
    longint sig, v;
    e   = int'(w[14:10]);
    sig = 1024 + longint'(w[9:0]);
    if (e == 0)  return 16'h0000;
    if (e == 31) return 16'hFFFF;
    v = (sig * (longint'(1) << e)) / (longint'(1) << 17);
    v = v % 65536;
    if (w[15]) v = (65536 - v) % 65536;
    return 16'(v);
  endfunction

  // Source responder: data for a request appears in the following cycle.
  initial begin
    bit          r;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      r = src_req && rst_n;
      a = src_addr;
      @(posedge clk);
      #1;
      src_rdata = r ? src_mem[a] : 16'hDEAD;
    end
  end

  initial begin
    int rel;
    forever begin
      @(posedge clk);
      #1;
      rel = cyc - start_cyc;
      dst_ready = !(stall_n > 0 && rel >= stall_from && rel < stall_from + stall_n);
    end
  end

  always @(negedge clk) begin
    int rel;
    bit ok;
    if (rst_n) begin
      rel = cyc - start_cyc;
      if (src_req) begin
        ok = m_active && (m_rd < m_len);
        chk("src_req_allowed", ok, 1);
        if (ok) begin
          chk("src_addr", src_addr, (m_src_base + m_rd) % 4096);
          rd_addr_log.push_back(int'(src_addr));
          rd_cyc_log.push_back(rel);
          m_rd++;
        end
      end
      if (dst_we && dst_ready) begin
        ok = m_active && (m_wr < m_len);
        chk("dst_write_allowed", ok, 1);
        if (ok) begin
          chk("dst_addr", dst_addr, (m_dst_base + m_wr) % 4096);
          chk("dst_wdata", dst_wdata, exp_q[m_wr]);
          wr_log.push_back(dst_wdata);
          wr_addr_log.push_back(int'(dst_addr));
          wr_cyc_log.push_back(rel);
          m_wr++;
        end
      end
      if (m_active) chk("pending_le2", (m_rd - m_wr) <= 2, 1);
      if (busy) begin
        busy_seen = 1;
        chk("busy_allowed", m_active, 1);
      end
      if (done) begin
        chk("done_allowed", m_active && (m_wr == m_len) && (m_rd == m_len), 1);
        chk("exc_cnt_at_done", exc_cnt, m_exc);
        chk("busy_in_done", busy, 0);
        done_rel  = rel;
        done_exc  = int'(exc_cnt);
        done_seen = 1;
        m_active  = 0;
      end
    end
  end

  task automatic start_job(input int sb, input int db, input int ln);
    logic [15:0] w;
    @(posedge clk);
    #1;
    cfg_src_base = AW'(sb);
    cfg_dst_base = AW'(db);
    cfg_len      = AW'(ln);
    cfg_start    = 1'b1;
    start_cyc    = cyc;
    m_src_base = sb; m_dst_base = db; m_len = ln;
    m_rd = 0; m_wr = 0; m_exc = 0;
    exp_q.delete(); wr_log.delete(); wr_addr_log.delete(); wr_cyc_log.delete();
    rd_addr_log.delete(); rd_cyc_log.delete();
    done_seen = 0; done_rel = -1; done_exc = -1; busy_seen = 0;
    for (int i = 0; i < ln; i++) begin
      w = src_mem[(sb + i) % 4096];
      exp_q.push_back(ref_cvt(w));
      if (w[14:10] == 5'd31) m_exc++;
    end
    m_active = 1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) @(posedge clk);
    chk("done_within_budget", done_seen, 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) src_mem[i] = 16'(i * 32'h0B3D + 32'h1234);
    src_mem[12'h010] = 16'h3C00; src_mem[12'h011] = 16'hC100;
    src_mem[12'h012] = 16'h3800; src_mem[12'h013] = 16'h7E00;
    src_mem[12'h100] = 16'h3C00; src_mem[12'h101] = 16'hBC00;
    src_mem[12'h102] = 16'h4000; src_mem[12'h103] = 16'h0001;
    src_mem[12'h104] = 16'h7C00; src_mem[12'h105] = 16'h5BFF;
    src_mem[12'h106] = 16'h1400; src_mem[12'h107] = 16'hFBFF;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_src_req", src_req, 0); chk("rst_dst_we", dst_we, 0);
    chk("rst_exc_cnt", exc_cnt, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Model pins against hand-computed conversions
    chk("ref_one", ref_cvt(16'h3C00), 16'h0100);
    chk("ref_neg", ref_cvt(16'hFBFF), 16'h2000);
    chk("ref_big", ref_cvt(16'h5BFF), 16'hFFE0);

    // Basic conversion
    start_job(12'h010, 12'h200, 4);
    wait_done(40);
    chk("basic_nwr", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("basic_w0", wr_log[0], 16'h0100); chk("basic_w1", wr_log[1], 16'hFD80);
      chk("basic_w2", wr_log[2], 16'h0080); chk("basic_w3", wr_log[3], 16'hFFFF);
      chk("basic_a0", wr_addr_log[0], 12'h200); chk("basic_a3", wr_addr_log[3], 12'h203);
      chk("basic_first_we_cyc", wr_cyc_log[0], 3); chk("basic_last_we_cyc", wr_cyc_log[3], 6);
    end
    chk("basic_done_cyc", done_rel, 7);
    chk("basic_exc", done_exc, 1);

    // Backpressure
    stall_from = 4; stall_n = 5;
    start_job(12'h100, 12'h300, 8);
    wait_done(80);
    stall_n = 0;
    chk("bp_nwr", wr_log.size(), 8);
    if (wr_log.size() == 8) begin
      chk("bp_w1_cyc", wr_cyc_log[1], 9);
      chk("bp_w3", wr_log[3], 16'h0000); chk("bp_w4", wr_log[4], 16'hFFFF);
      chk("bp_w7", wr_log[7], 16'h2000);
    end
    if (rd_cyc_log.size() == 8) chk("bp_rd3_cyc", rd_cyc_log[3], 9);
    else chk("bp_nrd", rd_cyc_log.size(), 8);
    chk("bp_exc", done_exc, 1);

    // Zero length
    start_job(12'h050, 12'h060, 0);
    wait_done(10);
    chk("zero_done_cyc", done_rel, 1);
    chk("zero_busy_seen", busy_seen, 0);
    chk("zero_nwr", wr_log.size(), 0);

    // Address wrap
    start_job(12'hFFE, 12'hFFD, 4);
    wait_done(40);
    chk("wrap_nrd", rd_addr_log.size(), 4);
    if (rd_addr_log.size() == 4) begin
      chk("wrap_r0", rd_addr_log[0], 12'hFFE); chk("wrap_r1", rd_addr_log[1], 12'hFFF);
      chk("wrap_r2", rd_addr_log[2], 12'h000); chk("wrap_r3", rd_addr_log[3], 12'h001);
    end
    if (wr_addr_log.size() == 4) chk("wrap_wa3", wr_addr_log[3], 12'h000);

    // Abort at cycle 4 of a len=10 job
    start_job(12'h400, 12'h500, 10);
    repeat (3) @(posedge clk);
    #1; cfg_abort = 1'b1;
    @(posedge clk);
    #1; cfg_abort = 1'b0; m_active = 0;
    chk("abort_busy_next", busy, 0);
    chk("abort_dst_we_next", dst_we, 0);
    repeat (15) @(posedge clk);
    chk("abort_no_done", done_seen, 0);
    start_job(12'h400, 12'h500, 3);
    wait_done(30);
    chk("abort_restart_nwr", wr_log.size(), 3);

    // Reset mid-DRAIN
    start_job(12'h600, 12'h700, 6);
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_src_req", src_req, 0);
    chk("pre_rst_dst_we", dst_we, 1);
    rst_n = 1'b0; m_active = 0;
    #1;
    chk("mid_rst_busy", busy, 0);       chk("mid_rst_done", done, 0);
    chk("mid_rst_src_req", src_req, 0); chk("mid_rst_dst_we", dst_we, 0);
    chk("mid_rst_src_addr", src_addr, 0); chk("mid_rst_dst_addr", dst_addr, 0);
    chk("mid_rst_wdata", dst_wdata, 0); chk("mid_rst_exc", exc_cnt, 0);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    repeat (6) @(posedge clk);
    start_job(12'h600, 12'h700, 6);
    wait_done(40);
    chk("post_rst_nwr", wr_log.size(), 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp16_fix_conv_ctrl.md
FP16_FIX_CONV_CTRL -- requirements
Module: fp16_fix_conv_ctrl

Interface
REQ-001 SHALL have parameter AW, default 12, meaning source/destination address width and length width.
REQ-002 SHALL have ports: clk input 1, the single clock for all state.
REQ-003 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have ports cfg_start input 1 (start pulse), cfg_abort input 1 (cancel job), and cfg_src_base / cfg_dst_base / cfg_len inputs AW (bases and element count, sampled at accepted start).
REQ-005 SHALL have outputs busy 1 (job active), done 1 (one-cycle completion pulse) and exc_cnt AW (NaN/Inf inputs seen in the current job).
REQ-006 SHALL have ports src_req output 1, src_addr output AW, and src_rdata input 16 (FP16 data, valid exactly one cycle after src_req).
REQ-007 SHALL have ports dst_we output 1, dst_addr output AW, dst_wdata output 16 (signed fixed point, 8 fraction bits) and dst_ready input 1 (write accepted when dst_we && dst_ready).

Function
REQ-008 SHALL implement FSM IDLE, RUN, DRAIN, DONE; busy=1 in RUN and DRAIN only.
REQ-009 In IDLE, cfg_start=1 SHALL latch the config and clear exc_cnt; it SHALL go to RUN if cfg_len!=0, else to DONE.
REQ-010 cfg_start outside IDLE SHALL be ignored.
REQ-011 RUN SHALL issue reads at src_base+i, i=0..len-1, at most one per cycle; it SHALL go to DRAIN in the cycle after the last read issues.
REQ-012 DRAIN SHALL go to DONE in the cycle after the len-th write is accepted.
REQ-013 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-014 Addresses SHALL wrap modulo 2^AW.
REQ-015 Results SHALL pass through a 2-entry result FIFO; src_req SHALL assert only when remaining>0 and (fifo_count + reads_in_flight) < 2, so no returned data is ever dropped.
REQ-016 dst_we SHALL equal FIFO non-empty; dst_addr SHALL be dst_base+j for the j-th result; the head SHALL pop only on acceptance.
REQ-017 With dst_ready held high, first dst_we SHALL be cycle 3 after the start cycle (cycle 1 src_req, cycle 2 rdata, cycle 3 write); throughput SHALL be 1 element/cycle thereafter.
REQ-018 Conversion of an element with sign s, exponent e and mantissa m SHALL be applied to src_rdata in its valid cycle and registered into the FIFO:
- e==0 -> 0x0000.
- e==31 -> 0xFFFF, and exc_cnt increments, saturating at all-ones.
- Otherwise magnitude = {1,m} shifted left by (e-17) if e>=17, else right by (17-e), truncated to 16 bits; the result is the two's-complement negation of the magnitude if s=1.
REQ-019 A simultaneous FIFO push and pop SHALL keep the count unchanged.
REQ-020 The FIFO SHALL never exceed 2 entries.
REQ-021 cfg_abort in RUN, DRAIN or DONE SHALL force IDLE next cycle, flush the FIFO, discard in-flight read data and suppress done.
REQ-022 cfg_abort in IDLE SHALL have no effect.
REQ-023 cfg_abort SHALL take priority over cfg_start in the same cycle.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE and set busy, done, src_req and dst_we to 0.
REQ-025 rst_n low SHALL set src_addr, dst_addr, dst_wdata and exc_cnt to 0, empty the FIFO and clear all counters.
REQ-026 Reset mid-job SHALL abandon the job with no further src_req or dst_we.
REQ-027 After reset deasserts, the block SHALL accept a new start.

Structure
REQ-028 The FSM state enum and FP16 field widths/constants (EXP_BIAS=15, FRAC_OUT=8) SHALL live in shared package fp16_acc_pkg.
REQ-029 The conversion SHALL be a separate combinational sub-module fp16_fix8_cvt.
REQ-030 The FIFO and FSM SHALL be inline in fp16_fix_conv_ctrl.

Verification
REQ-031 Basic conversion: len=4, src words 0x3C00, 0xC100, 0x3800, 0x7E00, dst_ready=1 -> writes 0x0100, 0xFD80, 0x0080, 0xFFFF at dst_base..+3 on cycles 3-6, done on cycle 7, exc_cnt=1.
REQ-032 Backpressure: len=8, dst_ready=0 for 5 cycles from cycle 4 -> at most 2 results pending, src_req low while stalled, 8 writes with no loss or duplication, correct order.
REQ-033 Zero length: len=0 -> no src_req or dst_we; done pulses in cycle 1; busy stays 0.
REQ-034 Address wrap: src_base=0xFFE, len=4 -> src_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
REQ-035 Abort: cfg_abort at cycle 4 of a len=10 job -> IDLE next cycle, no done, no dst_we afterwards; a new start then completes normally.
REQ-036 Reset: rst_n pulsed low mid-DRAIN -> all outputs 0 immediately; no writes until the next start.
